// File: rtl/divide_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : divide_pkg
//  Purpose  : Shared widths, iteration count, limit constants and the state
//             encoding for the signed restoring divider (divide_block).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package divide_pkg;

    localparam int DATA_W = 8;
    localparam int ITER_N = 8;
    localparam int CNT_W  = $clog2(ITER_N);

    // Most negative and most positive signed operand values
    localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    // State encoding constants
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ABS  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_SIGN = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        ABS  = ST_ABS,
        DIV  = ST_DIV,
        SIGN = ST_SIGN,
        DONE = ST_DONE
    } state_e;

endpackage
`default_nettype wire

// File: rtl/divide_complement_to_2.sv
`default_nettype none
// ============================================================================
//  Module   : divide_complement_to_2
//  Purpose  : Two-lane combinational two's-complement unit. Each lane passes
//             its input through, or negates it when its neg flag is set.
//             With neg = sign bit it yields the magnitude (|-128| = 8'h80,
//             read as unsigned 128).
//  Ports    : x0_i/x1_i  operand lanes
//             neg0_i/neg1_i  negate request per lane
//             y0_o/y1_o  results
//  Revision : 1.0 - initial release
// ============================================================================
module divide_complement_to_2
    import divide_pkg::*;
(
    input  logic [DATA_W-1:0] x0_i,
    input  logic              neg0_i,
    input  logic [DATA_W-1:0] x1_i,
    input  logic              neg1_i,
    output logic [DATA_W-1:0] y0_o,
    output logic [DATA_W-1:0] y1_o
);

    assign y0_o = neg0_i ? ((~x0_i) + DATA_W'(1)) : x0_i;
    assign y1_o = neg1_i ? ((~x1_i) + DATA_W'(1)) : x1_i;

endmodule
`default_nettype wire

// File: rtl/divide_block.sv
`default_nettype none
// ============================================================================
//  Module   : divide_block
//  Purpose  : 8-bit signed restoring divider, one quotient bit per cycle.
//             IDLE -> ABS -> DIV x8 -> SIGN -> DONE -> IDLE.
//             Start sampled at edge k gives divide_done in the cycle after
//             edge k+10. Truncates toward zero; remainder follows dividend.
//  Ports    : clk          system clock, rising edge
//             rst          asynchronous reset, active low
//             a, b         signed dividend / divisor
//             start        begin a division (only honoured in IDLE)
//             q, r         registered quotient / remainder
//             busy         operation in flight (ABS..DONE)
//             divide_done  one-cycle completion pulse
//             div_by_zero  b was zero (q = 0, r = a)
//             overflow     -128 / -1 (q saturated to 8'h7F, r = 0)
//  Revision : 1.0 - initial release
// ============================================================================
module divide_block
    import divide_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              start,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] r,
    output logic              busy,
    output logic              divide_done,
    output logic              div_by_zero,
    output logic              overflow
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    // |a| shifts out MSB first while quotient bits shift in at the LSB
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   mb_q, mb_d;
    // Stored remainder is always < |b| <= 128, so 8 bits suffice; the
    // 9-bit partial remainder exists only after the shift (shift_w).
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic [DATA_W-1:0]   r_q, r_d;
    logic                dz_q, dz_d;
    logic                ov_q, ov_d;

    // Complement unit: magnitudes in ABS, result signing in SIGN
    logic [DATA_W-1:0]   cu_x0, cu_x1, cu_y0, cu_y1;
    logic                cu_n0, cu_n1;

    always_comb begin
        if (state_q == SIGN) begin
            cu_x0 = dvd_q;
            cu_n0 = a_q[DATA_W-1] ^ b_q[DATA_W-1];
            cu_x1 = rem_q;
            cu_n1 = a_q[DATA_W-1];
        end else begin
            cu_x0 = a_q;
            cu_n0 = a_q[DATA_W-1];
            cu_x1 = b_q;
            cu_n1 = b_q[DATA_W-1];
        end
    end

    divide_complement_to_2 u_cmpl (
        .x0_i   (cu_x0),
        .neg0_i (cu_n0),
        .x1_i   (cu_x1),
        .neg1_i (cu_n1),
        .y0_o   (cu_y0),
        .y1_o   (cu_y1)
    );

    // Restoring step: shift in next dividend bit, trial-subtract |b|
    logic [DATA_W:0]     shift_w;
    logic                ge_w;

    assign shift_w = {rem_q, dvd_q[DATA_W-1]};
    assign ge_w    = (shift_w >= {1'b0, mb_q});

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = ABS;
                end
            end
            ABS: begin
                dvd_d   = cu_y0;
                mb_d    = cu_y1;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                rem_d = ge_w ? DATA_W'(shift_w - {1'b0, mb_q})
                             : shift_w[DATA_W-1:0];
                dvd_d = {dvd_q[DATA_W-2:0], ge_w};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_N - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                dz_d = (b_q == '0);
                ov_d = (a_q == DATA_MIN) && (b_q == '1);
                if (b_q == '0) begin
                    q_d = '0;
                    r_d = a_q;
                end else if ((a_q == DATA_MIN) && (b_q == '1)) begin
                    // +128 is not representable: saturate
                    q_d = DATA_MAX;
                    r_d = '0;
                end else begin
                    q_d = cu_y0;
                    r_d = cu_y1;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvd_q   <= dvd_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;
    assign busy        = (state_q != IDLE);
    assign divide_done = (state_q == DONE);

endmodule
`default_nettype wire
